// File: rtl/disp_pkg.sv
// Shared display definitions: scan FSM states and active-low seven-segment patterns
// (bit 7 = decimal point, bits 6..0 = g..a).
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG0 = 8'hC0;
  localparam logic [7:0] SEG1 = 8'hF9;
  localparam logic [7:0] SEG2 = 8'hA4;
  localparam logic [7:0] SEG3 = 8'hB0;
  localparam logic [7:0] SEG4 = 8'h99;
  localparam logic [7:0] SEG5 = 8'h92;
  localparam logic [7:0] SEG6 = 8'h82;
  localparam logic [7:0] SEG7 = 8'hF8;
  localparam logic [7:0] SEG8 = 8'h80;
  localparam logic [7:0] SEG9 = 8'h90;
  localparam logic [7:0] SEGA = 8'h88;
  localparam logic [7:0] SEGB = 8'h83;
  localparam logic [7:0] SEGC = 8'hC6;
  localparam logic [7:0] SEGD = 8'hA1;
  localparam logic [7:0] SEGE = 8'h86;
  localparam logic [7:0] SEGF = 8'h8E;
  localparam logic [7:0] SEGERROR = 8'hBF;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter for the scan FSM: clears, increments and flags the terminal count.
// With DISPLAY_DIM_EN the low nibble is exported for PWM dimming.
module seg_scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
`ifdef DISPLAY_DIM_EN
  output logic [3:0]       cnt_lo_o,
`endif
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);
`ifdef DISPLAY_DIM_EN
  assign cnt_lo_o = cnt_q[3:0];
`endif

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: shadow/active frame buffers, ON/BLANK digit slots.
// DISPLAY_DIM_EN adds brightness_i PWM within the ON phase.
module seg_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SEG_W     = 8,
  parameter int ON_CYC    = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
`ifdef DISPLAY_DIM_EN
  input  logic [3:0]                 brightness_i,
`endif
  input  logic                       frame_valid_i,
  input  logic [SEG_W-1:0]           frame_i [DIGITS],
  output logic                       frame_ready_o,
  output logic [DIGITS-1:0]          an_o,
  output logic [SEG_W-1:0]           seg_o,
  output logic [$clog2(DIGITS)-1:0]  digit_idx_o,
  output logic                       frame_done_o
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] ON_TC    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_TC = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic [SEG_W-1:0] BLANK_PAT = {SEG_W{1'b1}};

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             done_q, done_d;
  logic             full_q;
  logic [SEG_W-1:0] active_q [DIGITS];
  logic [SEG_W-1:0] shadow_q [DIGITS];

  logic             accept, swap, eos, lit;
  logic             cnt_clr, cnt_en, tc;
  logic [CNT_W-1:0] tc_val;

`ifdef DISPLAY_DIM_EN
  logic [3:0] cnt_lo;
  assign lit = (cnt_lo <= brightness_i);
`else
  assign lit = 1'b1;
`endif

  seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (tc_val),
`ifdef DISPLAY_DIM_EN
    .cnt_lo_o (cnt_lo),
`endif
    .tc_o     (tc)
  );

  assign accept = frame_valid_i & ~full_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    an_d    = '1;
    seg_d   = BLANK_PAT;
    done_d  = 1'b0;
    swap    = 1'b0;
    eos     = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    tc_val  = (state_q == BLANK) ? BLANK_TC : ON_TC;
    case (state_q)
      IDLE: begin
        swap    = full_q;
        cnt_clr = 1'b1;
        idx_d   = '0;
        if (enable_i) state_d = ON;
      end
      ON: begin
        if (!enable_i) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else begin
          if (lit) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = active_q[idx_q];
          end
          if (tc) begin
            cnt_clr = 1'b1;
            if (BLANK_CYC == 0) eos = 1'b1;
            else                state_d = BLANK;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      BLANK: begin
        if (!enable_i) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else if (tc) begin
          cnt_clr = 1'b1;
          eos     = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame boundary is the only point besides IDLE where the active buffer may change
    if (eos) begin
      state_d = ON;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        done_d = 1'b1;
        swap   = full_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= BLANK_PAT;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      for (int k = 0; k < DIGITS; k++) active_q[k] <= BLANK_PAT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
      if (accept)    full_q <= 1'b1;
      else if (swap) full_q <= 1'b0;
      if (swap) active_q <= shadow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) shadow_q <= frame_i;
  end

  assign frame_ready_o = ~full_q;
  assign an_o          = an_q;
  assign seg_o         = seg_q;
  assign digit_idx_o   = idx_q;
  assign frame_done_o  = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table-driven scan vectors plus handshake,
// enable-drop, reset and zero-blank sequences.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, valid;
  logic       rst0_n, en0, valid0;
  logic [3:0] bright;
  logic [7:0] frame [8];
  logic       ready, done, ready0, done0;
  logic [7:0] an, seg, an0, seg0;
  logic [2:0] idx, idx0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(8), .SEG_W(8), .ON_CYC(4), .BLANK_CYC(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
`ifdef DISPLAY_DIM_EN
    .brightness_i(bright),
`endif
    .frame_valid_i(valid), .frame_i(frame), .frame_ready_o(ready),
    .an_o(an), .seg_o(seg), .digit_idx_o(idx), .frame_done_o(done)
  );

  seg_scan_ctrl #(.DIGITS(8), .SEG_W(8), .ON_CYC(4), .BLANK_CYC(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .enable_i(en0),
`ifdef DISPLAY_DIM_EN
    .brightness_i(bright),
`endif
    .frame_valid_i(valid0), .frame_i(frame), .frame_ready_o(ready0),
    .an_o(an0), .seg_o(seg0), .digit_idx_o(idx0), .frame_done_o(done0)
  );

  typedef struct {
    logic       en;
    logic [7:0] an;
    logic [7:0] seg;
    logic [7:0] done;
    logic [7:0] idx;
  } vec_t;

  vec_t tbl [96];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic load(input int base);
    for (int k = 0; k < 8; k++) frame[k] = 8'(base + k);
  endtask

  task automatic wait_an(input logic [7:0] v, input int budget, input string name);
    int n = 0;
    while (an !== v && n < budget) begin
      tick();
      n++;
    end
    chk(name, an, v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic lit;
    logic [7:0] e_an, e_seg;
    // Expected outputs for 2 frames, sample 0 = first lit cycle of digit 0
    for (int c = 0; c < 96; c++) begin
      tbl[c].en   = 1'b1;
      tbl[c].an   = ((c % 6) < 4) ? ~(8'd1 << ((c / 6) % 8)) : 8'hFF;
      tbl[c].seg  = ((c % 6) < 4) ? 8'(16 + (c / 6) % 8) : 8'hFF;
      tbl[c].done = ((c % 48) == 47) ? 8'd1 : 8'd0;
      tbl[c].idx  = 8'(((c + 1) / 6) % 8);
    end

    rst_n = 1'b0; en = 1'b1; valid = 1'b0; bright = 4'hF;
    rst0_n = 1'b0; en0 = 1'b0; valid0 = 1'b0;
    load(0);
    repeat (3) tick();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_ready", 8'(ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_idx", 8'(idx), 8'd0);

    // Load frame A while idle, then start scanning
    rst_n = 1'b1; en = 1'b0; load(16); valid = 1'b1;
    tick();
    chk("a_accept_ready", 8'(ready), 8'd0);
    valid = 1'b0; en = 1'b1;
    tick();
    chk("a_swap_ready", 8'(ready), 8'd1);
    chk("a_start_an", an, 8'hFF);
    for (int c = 0; c < 96; c++) begin
      en = tbl[c].en;
      tick();
      chk($sformatf("scan_an[%0d]", c), an, tbl[c].an);
      chk($sformatf("scan_seg[%0d]", c), seg, tbl[c].seg);
      chk($sformatf("scan_done[%0d]", c), 8'(done), tbl[c].done);
      chk($sformatf("scan_idx[%0d]", c), 8'(idx), tbl[c].idx);
    end

    // Frame B mid-scan accepted; C held off until the boundary
    chk("b_ready_before", 8'(ready), 8'd1);
    load(32); valid = 1'b1;
    tick();
    chk("b_accepted", 8'(ready), 8'd0);
    load(48);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c_held_off", 8'(ready), 8'd0);
    end
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("b_boundary_done", 8'(done), 8'd1);
    chk("b_boundary_ready", 8'(ready), 8'd1);
    valid = 1'b0;
    tick();
    chk("b_d0_an", an, 8'hFE);
    chk("b_d0_seg", seg, 8'h20);
    chk("b_ready_after", 8'(ready), 8'd1);

    // Drop enable while digit 3 is lit
    wait_an(8'hF7, 60, "d3_reached");
    en = 1'b0;
    tick();
    chk("dis_an", an, 8'hFF);
    chk("dis_seg", seg, 8'hFF);
    chk("dis_idx", 8'(idx), 8'd0);
    chk("dis_done", 8'(done), 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_hold_an", an, 8'hFF);
      chk("dis_hold_done", 8'(done), 8'd0);
    end
    en = 1'b1;
    tick();
    chk("reen_an0", an, 8'hFF);
    tick();
    chk("reen_an", an, 8'hFE);
    chk("reen_seg", seg, 8'h20);
    chk("reen_idx", 8'(idx), 8'd0);

    // Reset mid-BLANK with a frame pending in the shadow
    load(80); valid = 1'b1;
    tick();
    chk("d_accepted", 8'(ready), 8'd0);
    valid = 1'b0;
    wait_an(8'hFF, 20, "blank_reached");
    rst_n = 1'b0;
    tick();
    chk("mrst_an", an, 8'hFF);
    chk("mrst_seg", seg, 8'hFF);
    chk("mrst_ready", 8'(ready), 8'd1);
    chk("mrst_done", 8'(done), 8'd0);
    chk("mrst_idx", 8'(idx), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("mrst_start_an", an, 8'hFF);
    tick();
    chk("mrst_d0_an", an, 8'hFE);
    chk("mrst_d0_seg", seg, 8'hFF);
    wait_an(8'hFD, 10, "mrst_d1_reached");
    chk("mrst_d1_seg", seg, 8'hFF);

    // Zero-blank instance: 4-cycle slots, 32-cycle frame
    rst0_n = 1'b1; load(64); valid0 = 1'b1;
`ifdef DISPLAY_DIM_EN
    bright = 4'h1;
`endif
    tick();
    chk("z_accept", 8'(ready0), 8'd0);
    valid0 = 1'b0; en0 = 1'b1;
    tick();
    for (int c = 0; c < 64; c++) begin
      tick();
`ifdef DISPLAY_DIM_EN
      lit = (c % 4) <= 1;
`else
      lit = 1'b1;
`endif
      e_an  = lit ? ~(8'd1 << ((c / 4) % 8)) : 8'hFF;
      e_seg = lit ? 8'(64 + (c / 4) % 8) : 8'hFF;
      chk($sformatf("z_an[%0d]", c), an0, e_an);
      chk($sformatf("z_seg[%0d]", c), seg0, e_seg);
      chk($sformatf("z_done[%0d]", c), 8'(done0), ((c % 32) == 31) ? 8'd1 : 8'd0);
      chk($sformatf("z_idx[%0d]", c), 8'(idx0), 8'(((c + 1) / 4) % 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
